// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, condition codes,
// instruction field positions and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_ORR = 4'b0100;
  localparam logic [3:0] OP_EOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SHF = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int COND_LSB = 28;
  localparam int OPC_LSB  = 24;
  localparam int S_BIT    = 23;
  localparam int RD_LSB   = 19;
  localparam int RN_LSB   = 15;
  localparam int RM_LSB   = 11;
  localparam int SRC_LSB  = 8;
  localparam int SRB_LSB  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_e;

  // Opcodes the ALU implements; anything else retires as illegal.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_SHF,
      OP_CMP, OP_LDR, OP_STR: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code check of cond[3:0] against flags {N,Z,C,V}.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;
  assign {n_s, z_s, c_s, v_s} = flags;

  // Condition decode
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = !z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = !c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = !n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = !v_s;
      COND_HI: pass = c_s && !z_s;
      COND_LS: pass = !c_s || z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = !z_s && (n_s == v_s);
      COND_LE: pass = z_s || (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the shared ALU (IDLE -> EXEC -> WB).
// Optional build macro ALU_MUL_MULTICYCLE_EN stretches EXEC to MUL_LAT cycles for multiply.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 32
`ifdef ALU_MUL_MULTICYCLE_EN
  , parameter int MUL_LAT = 3
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [3:0]      rf_addr_a,
  output logic [3:0]      rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_opcode,
  output logic [2:0]      alu_sr_cont,
  output logic [4:0]      alu_sr_bit,
  output logic            alu_s,
  output logic [15:0]     alu_imm,
  input  logic [XLEN-1:0] alu_out,
  input  logic [3:0]      alu_flags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [3:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_store,
  output logic [3:0]      flags_q,
  output logic            skipped,
  output logic            illegal,
  output logic            busy
);

  state_e            state_r;
  logic [XLEN-1:0]   alu_in1_r, alu_in2_r, wb_data_r;
  logic [3:0]        alu_opcode_r, wb_addr_r, flags_r;
  logic [2:0]        alu_sr_cont_r;
  logic [4:0]        alu_sr_bit_r;
  logic [15:0]       alu_imm_r;
  logic              alu_s_r, is_cmp_r, wb_valid_r, wb_store_r;
  logic              skipped_r, illegal_r;

  logic [3:0]        cond_s, opc_s;
  logic              cond_pass_s, accept_s, is_cmp_s, exec_done_s;

  assign cond_s    = instr[COND_LSB +: 4];
  assign opc_s     = instr[OPC_LSB +: 4];
  assign is_cmp_s  = (opc_s == OP_CMP);
  assign rf_addr_a = instr[RN_LSB +: 4];
  assign rf_addr_b = instr[RM_LSB +: 4];

  assign instr_ready = (state_r == IDLE) && rst_n;
  assign accept_s    = instr_valid && instr_ready;
  assign busy        = (state_r != IDLE);

  alu_cond_eval u_cond (
    .cond  (cond_s),
    .flags (flags_r),
    .pass  (cond_pass_s)
  );

`ifdef ALU_MUL_MULTICYCLE_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  logic [CNT_W-1:0] mul_cnt_r;

  // Multiply latency down-counter; loaded at issue, EXEC ends when it reaches zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && (opc_s == OP_MUL)) begin
      mul_cnt_r <= CNT_W'(MUL_LAT - 1);
    end else if ((state_r == EXEC) && (mul_cnt_r != {CNT_W{1'b0}})) begin
      mul_cnt_r <= mul_cnt_r - CNT_W'(1);
    end else begin
      mul_cnt_r <= mul_cnt_r;
    end
  end

  assign exec_done_s = (mul_cnt_r == {CNT_W{1'b0}});
`else
  assign exec_done_s = 1'b1;
`endif

  // Issue FSM with all datapath and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      alu_in1_r     <= {XLEN{1'b0}};
      alu_in2_r     <= {XLEN{1'b0}};
      alu_opcode_r  <= 4'b0000;
      alu_sr_cont_r <= 3'b000;
      alu_sr_bit_r  <= 5'b00000;
      alu_s_r       <= 1'b0;
      alu_imm_r     <= 16'h0000;
      is_cmp_r      <= 1'b0;
      wb_valid_r    <= 1'b0;
      wb_addr_r     <= 4'b0000;
      wb_data_r     <= {XLEN{1'b0}};
      wb_store_r    <= 1'b0;
      flags_r       <= 4'b0000;
      skipped_r     <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      skipped_r <= 1'b0;
      illegal_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (!cond_pass_s) begin
              skipped_r <= 1'b1;
            end else if (!op_is_legal(opc_s)) begin
              illegal_r <= 1'b1;
            end else begin
              alu_in1_r     <= rf_data_a;
              alu_in2_r     <= rf_data_b;
              alu_opcode_r  <= is_cmp_s ? OP_SUB : opc_s;
              alu_s_r       <= instr[S_BIT] || is_cmp_s;
              alu_sr_cont_r <= instr[SRC_LSB +: 3];
              alu_sr_bit_r  <= instr[SRB_LSB +: 5];
              alu_imm_r     <= instr[15:0];
              is_cmp_r      <= is_cmp_s;
              wb_addr_r     <= instr[RD_LSB +: 4];
              wb_store_r    <= (opc_s == OP_STR);
              state_r       <= EXEC;
            end
          end
        end
        EXEC: begin
          if (exec_done_s) begin
            wb_data_r <= alu_out;
            if (alu_s_r) begin
              flags_r <= alu_flags;
            end
            if (is_cmp_r) begin
              state_r <= IDLE;
            end else begin
              wb_valid_r <= 1'b1;
              state_r    <= WB;
            end
          end
        end
        WB: begin
          // Result and address hold until the consumer takes them
          if (wb_ready) begin
            wb_valid_r <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          wb_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign alu_in1     = alu_in1_r;
  assign alu_in2     = alu_in2_r;
  assign alu_opcode  = alu_opcode_r;
  assign alu_sr_cont = alu_sr_cont_r;
  assign alu_sr_bit  = alu_sr_bit_r;
  assign alu_s       = alu_s_r;
  assign alu_imm     = alu_imm_r;
  assign wb_valid    = wb_valid_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign wb_store    = wb_store_r;
  assign flags_q     = flags_r;
  assign skipped     = skipped_r;
  assign illegal     = illegal_r;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that sequences the shared 32-bit ALU. It:
- accepts one 32-bit instruction per handshake;
- evaluates the 4-bit Cond field against the architectural {N,Z,C,V} flags register it owns;
- fetches operands from the register file and drives the ALU controls;
- returns the result through a valid/ready write-back port.

It sits between instruction fetch, the register file and the ALU.

Parameters:
- XLEN, 32, data width of operands/result
- MUL_LAT, 3, EXEC cycles for multiply when ALU_MUL_MULTICYCLE_EN is defined (min 1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  32  [31:28] cond, [27:24] opcode, [23] S, [22:19] rd, [18:15] rn, [14:11] rm, [10:8] sr_cont, [7:3] sr_bit, [15:0] imm
- rf_addr_a  out  4  register file read address A (= rn)
- rf_addr_b  out  4  register file read address B (= rm)
- rf_data_a  in  XLEN  combinational read data A
- rf_data_b  in  XLEN  combinational read data B
- alu_in1, alu_in2  out  XLEN  registered ALU operands
- alu_opcode  out  4  ALU opcode
- alu_sr_cont  out  3  ALU shift control
- alu_sr_bit  out  5  ALU shift amount
- alu_s  out  1  ALU flag-set enable
- alu_imm  out  16  ALU immediate
- alu_out  in  XLEN  ALU result
- alu_flags  in  4  ALU flags {N,Z,C,V}
- wb_valid  out  1  result available
- wb_ready  in  1  consumer accepts result
- wb_addr  out  4  destination register
- wb_data  out  XLEN  result data
- wb_store  out  1  1 = result is a store payload, not a register write
- flags_q  out  4  architectural flags {N,Z,C,V}
- skipped  out  1  one-cycle pulse: condition failed, instruction retired with no effect
- illegal  out  1  one-cycle pulse: undefined opcode retired
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge, in any state, including mid-EXEC or mid-WB):
  - state=IDLE, flags_q=0, wb_valid=0, skipped=0, illegal=0;
  - all alu_* outputs=0; any in-flight instruction is dropped.
- instr_ready = (state==IDLE) && rst_n. Handshake completes when instr_valid && instr_ready.
- IDLE, on handshake, evaluate cond against the current flags_q:
  - EQ/NE (0000/0001): Z / !Z
  - CS/CC (0010/0011): C / !C
  - MI/PL (0100/0101): N / !N
  - VS/VC (0110/0111): V / !V
  - HI/LS (1000/1001): C&!Z / !C|Z
  - GE/LT (1010/1011): N==V / N!=V
  - GT/LE (1100/1101): !Z&(N==V) / Z|(N!=V)
  - AL (1110): always true
  - 1111: always false
- IDLE, condition false: pulse skipped for 1 cycle; stay in IDLE; no ALU, write-back or flag change.
- IDLE, condition true: latch rf_data_a/b and the decode fields into the alu_* registers; go to EXEC.
- Opcode handling:
  - 0000-0111, 1101, 1110: passed through to alu_opcode.
  - 1000 CMP: alu_opcode=0001, alu_s forced 1, no write-back.
  - 1001-1100, 1111: pulse illegal; stay in IDLE; flags unchanged.
- EXEC (1 cycle):
  - capture alu_out into wb_data;
  - if S=1 or CMP, flags_q <= alu_flags at end of EXEC;
  - CMP goes to IDLE; all others go to WB.
- WB:
  - wb_valid=1; wb_addr=rd; wb_store=(opcode==1110);
  - wb_data and wb_addr stay stable until wb_ready;
  - on wb_valid && wb_ready, go to IDLE the next cycle.
- Latency: handshake at edge T; wb_valid high from T+2. Minimum throughput is 1 instruction per 3 cycles (CMP: 2).
- Flag hazard: flags written in EXEC are visible to the cond check of the next accepted instruction.
- A simultaneous instr_valid while busy is ignored, not lost: instr_ready=0.

Optional Feature:
- Macro ALU_MUL_MULTICYCLE_EN.
- Defined: opcode 0010 holds EXEC for MUL_LAT cycles using a down-counter. ALU inputs are held constant; wb_data is captured on the final EXEC cycle. Reset mid-count clears the counter.
- Undefined: multiply takes the same single EXEC cycle as every other opcode; no counter is synthesized.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: OP_ADD .. OP_STR, OP_CMP=4'b1000;
  - cond code constants;
  - instruction field bit positions;
  - FSM state encoding: IDLE, EXEC, WB.
- Sub-module alu_cond_eval: combinational cond[3:0] + flags[3:0] -> pass.

Test Plan:
- ADD r3=r1+r2, cond AL, rf_data_a=5, rf_data_b=7 -> wb_valid at T+2, wb_addr=3, wb_data=12, flags_q unchanged.
- CMP with a=9, b=9, then ADDEQ -> flags_q Z=1 after EXEC; the ADDEQ executes. A following NE instruction pulses skipped and produces no wb_valid.
- wb_ready held 0 for 4 cycles -> wb_valid, wb_data and wb_addr stay stable; instr_ready stays 0; accept occurs 1 cycle after wb_ready=1.
- Opcode 1010 -> illegal pulses for 1 cycle, instr_ready is 1 the next cycle, no wb_valid.
- rst_n=0 during WB with wb_valid=1 -> next cycle wb_valid=0, flags_q=0, state IDLE, instr_ready=1.
- With ALU_MUL_MULTICYCLE_EN and MUL_LAT=3: MUL 6*7 -> wb_valid at T+4, wb_data=42.
